// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared types and helpers for the buzzer arbiter.
//   state_e  : arbiter FSM state (IDLE/ON/GAP, 2-bit encoding)
//   NUM_REQ  : number of alarm requesters (3)
//   TIMER_W  : width of the on/gap timers and the tone counter
//   onehot3  : 2-bit index -> 3-bit one-hot (0 for an out-of-range index)
//   inc3     : index + 1 modulo 3
package buzzer_pkg;

   localparam int NUM_REQ = 3;
   localparam int TIMER_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_e;

   function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
      case (idx)
         2'd0:    onehot3 = 3'b001;
         2'd1:    onehot3 = 3'b010;
         2'd2:    onehot3 = 3'b100;
         default: onehot3 = 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] inc3(input logic [1:0] idx);
      inc3 = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/buzzer_arbiter_rr_pick3.sv
// rr_pick3: combinational winner selection among three pending requests.
//   pend_i : pending request bits
//   rr_i   : round-robin start index (absent in the fixed-priority build)
//   win_o  : index of the selected requester (0 when none)
//   vld_o  : a winner exists (pend_i != 0)
// Build option: BUZZER_ARB_FIXED_PRIO_EN selects lowest-index-wins instead
// of scanning from rr_i.
module rr_pick3
   import buzzer_pkg::*;
(
   input  logic [NUM_REQ-1:0] pend_i,
`ifndef BUZZER_ARB_FIXED_PRIO_EN
   input  logic [1:0]         rr_i,
`endif
   output logic [1:0]         win_o,
   output logic               vld_o
);

`ifdef BUZZER_ARB_FIXED_PRIO_EN
   always_comb begin
      win_o = 2'd0;
      vld_o = 1'b1;
      if      (pend_i[0]) win_o = 2'd0;
      else if (pend_i[1]) win_o = 2'd1;
      else if (pend_i[2]) win_o = 2'd2;
      else                vld_o = 1'b0;
   end
`else
   logic [1:0] c0, c1, c2;

   // Scan order rr, rr+1, rr+2 (mod 3); first set bit wins.
   always_comb begin
      c0    = rr_i;
      c1    = inc3(c0);
      c2    = inc3(c1);
      win_o = 2'd0;
      vld_o = 1'b1;
      if      (pend_i[c0]) win_o = c0;
      else if (pend_i[c1]) win_o = c1;
      else if (pend_i[c2]) win_o = c2;
      else                 vld_o = 1'b0;
   end
`endif

endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one piezo pin between three alarm requesters.
// Rising edges on req_i latch sticky pending bits; requesters are granted one
// at a time for an ON_CYC-cycle tone burst followed by GAP_CYC silent cycles.
// The tone half-period is TONE_HALF << index, so pitch identifies the source.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low freezes every register
//   req_i      : per-requester alarm level
//   buzz_o     : square wave during a burst, 0 otherwise
//   grant_o    : one-hot requester being sounded
//   pend_o     : requested but not yet granted
//   busy_o     : high in ON or GAP
// Build option: BUZZER_ARB_FIXED_PRIO_EN replaces round-robin with fixed
// priority (requester 0 highest) and removes the rr pointer.
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int ON_CYC    = 31,
   parameter int GAP_CYC   = 4,
   parameter int TONE_HALF = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [NUM_REQ-1:0] req_i,
   output logic               buzz_o,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [NUM_REQ-1:0] pend_o,
   output logic               busy_o
);

   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYC - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYC - 1);
   localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

   state_e               state_q, state_d;
   logic                 buzz_q, buzz_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   pend_q, pend_d;
   logic [NUM_REQ-1:0]   prev_q;
   logic [TIMER_W-1:0]   on_q, on_d;
   logic [TIMER_W-1:0]   gap_q, gap_d;
   logic [TIMER_W-1:0]   tone_q, tone_d;
   logic [TIMER_W-1:0]   tone_lim;
   logic [1:0]           w_q, w_d;
   logic [NUM_REQ-1:0]   clr;
   logic [1:0]           win;
   logic                 win_vld;
`ifndef BUZZER_ARB_FIXED_PRIO_EN
   logic [1:0]           rr_q, rr_d;
`endif

   rr_pick3 u_pick (
      .pend_i (pend_q),
`ifndef BUZZER_ARB_FIXED_PRIO_EN
      .rr_i   (rr_q),
`endif
      .win_o  (win),
      .vld_o  (win_vld)
   );

   always_comb begin
      state_d  = state_q;
      buzz_d   = buzz_q;
      grant_d  = grant_q;
      on_d     = on_q;
      gap_d    = gap_q;
      tone_d   = tone_q;
      w_d      = w_q;
      clr      = '0;
`ifndef BUZZER_ARB_FIXED_PRIO_EN
      rr_d     = rr_q;
`endif
      tone_lim = (TIMER_W'(TONE_HALF) << w_q) - ONE;

      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = ON;
               grant_d = onehot3(win);
               clr     = onehot3(win);
               on_d    = ON_LOAD;
               tone_d  = '0;
               buzz_d  = 1'b1;
               w_d     = win;
`ifndef BUZZER_ARB_FIXED_PRIO_EN
               rr_d    = inc3(win);
`endif
            end
         end
         ON: begin
            if (tone_q == tone_lim) begin
               buzz_d = ~buzz_q;
               tone_d = '0;
            end else begin
               tone_d = tone_q + ONE;
            end
            if (on_q == '0) begin
               state_d = GAP;
               grant_d = '0;
               buzz_d  = 1'b0;
               tone_d  = '0;
               gap_d   = GAP_LOAD;
            end else begin
               on_d = on_q - ONE;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - ONE;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            buzz_d  = 1'b0;
            on_d    = '0;
            gap_d   = '0;
            tone_d  = '0;
         end
      endcase

      // Set after clear: an edge arriving on the grant cycle re-queues.
      pend_d = (pend_q & ~clr) | (req_i & ~prev_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         buzz_q  <= 1'b0;
         grant_q <= '0;
         pend_q  <= '0;
         prev_q  <= '0;
         on_q    <= '0;
         gap_q   <= '0;
         tone_q  <= '0;
         w_q     <= '0;
`ifndef BUZZER_ARB_FIXED_PRIO_EN
         rr_q    <= '0;
`endif
      end else if (ena) begin
         state_q <= state_d;
         buzz_q  <= buzz_d;
         grant_q <= grant_d;
         pend_q  <= pend_d;
         prev_q  <= req_i;
         on_q    <= on_d;
         gap_q   <= gap_d;
         tone_q  <= tone_d;
         w_q     <= w_d;
`ifndef BUZZER_ARB_FIXED_PRIO_EN
         rr_q    <= rr_d;
`endif
      end
   end

   assign buzz_o  = buzz_q;
   assign grant_o = grant_q;
   assign pend_o  = pend_q;
   assign busy_o  = (state_q == ON) || (state_q == GAP);

endmodule

// File: tb/tb_buzzer_arbiter.sv
module tb_buzzer_arbiter;

   localparam int ON_CYC    = 31;
   localparam int GAP_CYC   = 4;
   localparam int TONE_HALF = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [2:0] req_i = 3'b000;
   logic       buzz_o;
   logic [2:0] grant_o;
   logic [2:0] pend_o;
   logic       busy_o;

   buzzer_arbiter #(.ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC), .TONE_HALF(TONE_HALF)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .req_i   (req_i),
      .buzz_o  (buzz_o),
      .grant_o (grant_o),
      .pend_o  (pend_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]      req;
      logic [1:0]      n;
      logic [2:0][2:0] g;
      logic [2:0][7:0] h;
   } vec_t;

   typedef struct {
      logic [2:0] grant;
      int         half;
   } exp_t;

   int   nchecks = 0;
   int   nerr    = 0;
   exp_t sbq[$];
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_i = 3'b000;
      ena   = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_out", {29'd0, buzz_o, busy_o, 1'b0} | {23'd0, grant_o, pend_o, 3'd0},
          32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Waits for a grant, then checks the ON_CYC-cycle burst and the first gap cycle.
   task automatic burst(input logic [2:0] eg, input int half, input int hold_at,
                        output int waited);
      int bad, hbad;
      logic hb;
      logic [2:0] hg;
      bad = 0;
      hbad = 0;
      waited = 0;
      while (grant_o == 3'b000 && waited < 300) begin
         step();
         waited++;
      end
      chk("grant", {29'd0, grant_o}, {29'd0, eg});
      if (grant_o == 3'b000) return;
      for (int k = 0; k < ON_CYC; k++) begin
         if (k > 0) step();
         if (grant_o !== eg || buzz_o !== (((k / half) % 2) == 0) || busy_o !== 1'b1)
            bad++;
         if (k == hold_at) begin
            hb  = buzz_o;
            hg  = grant_o;
            ena = 1'b0;
            for (int i = 0; i < 10; i++) begin
               step();
               if (buzz_o !== hb || grant_o !== hg || busy_o !== 1'b1) hbad++;
            end
            ena = 1'b1;
            chk("ena_hold", hbad, 0);
         end
      end
      chk("burst_wave", bad, 0);
      step();
      chk("burst_end", {28'd0, busy_o, grant_o, buzz_o} , {28'd0, 1'b1, 3'b000, 1'b0});
   endtask

   // Remaining gap cycles silent, then one IDLE cycle with busy low.
   task automatic gap_rest();
      int bad;
      bad = 0;
      for (int i = 0; i < GAP_CYC - 1; i++) begin
         step();
         if (busy_o !== 1'b1 || grant_o !== 3'b000 || buzz_o !== 1'b0) bad++;
      end
      chk("gap_silent", bad, 0);
      step();
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic pulse(input logic [2:0] r);
      req_i = r;
      step();
      chk("pend_set", {29'd0, pend_o}, {29'd0, r});
      req_i = 3'b000;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w, bad, first;
      exp_t e;

      vecs[0] = '{req: 3'b001, n: 2'd1, g: {3'b000, 3'b000, 3'b001}, h: {8'd0, 8'd0, 8'd2}};
      vecs[1] = '{req: 3'b111, n: 2'd3, g: {3'b100, 3'b010, 3'b001}, h: {8'd8, 8'd4, 8'd2}};
      vecs[2] = '{req: 3'b110, n: 2'd2, g: {3'b000, 3'b100, 3'b010}, h: {8'd0, 8'd8, 8'd4}};
      vecs[3] = '{req: 3'b100, n: 2'd1, g: {3'b000, 3'b000, 3'b100}, h: {8'd0, 8'd0, 8'd8}};
      vecs[4] = '{req: 3'b101, n: 2'd2, g: {3'b000, 3'b100, 3'b001}, h: {8'd0, 8'd8, 8'd2}};

      // Table: each row from reset, one pulse, expected burst sequence.
      for (int r = 0; r < 5; r++) begin
         do_reset();
         pulse(vecs[r].req);
         for (int j = 0; j < int'(vecs[r].n); j++)
            sbq.push_back('{grant: vecs[r].g[j], half: int'(vecs[r].h[j])});
         first = 1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            burst(e.grant, e.half, -1, w);
            if (first == 1) chk("arb_latency", w, 1);
            else            chk("gap_len", w, GAP_CYC + 1);
            first = 0;
         end
         gap_rest();
         chk("pend_empty", {29'd0, pend_o}, 32'd0);
      end

      // Re-request during GAP: round-robin resumes at requester 1.
      do_reset();
      pulse(3'b001);
      burst(3'b001, 2, -1, w);
      req_i = 3'b011;
      sbq.push_back('{grant: 3'b010, half: 4});
      sbq.push_back('{grant: 3'b001, half: 2});
      gap_rest();
      req_i = 3'b000;
      e = sbq.pop_front();
      burst(e.grant, e.half, -1, w);
      e = sbq.pop_front();
      burst(e.grant, e.half, -1, w);
      chk("rr_gap_len", w, GAP_CYC + 1);
      gap_rest();

      // Level held high: one burst only, re-arms after a falling edge.
      do_reset();
      req_i = 3'b100;
      step();
      chk("held_pend", {29'd0, pend_o}, 32'd4);
      burst(3'b100, 8, -1, w);
      gap_rest();
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (grant_o !== 3'b000 || pend_o !== 3'b000 || busy_o !== 1'b0) bad++;
      end
      chk("held_once", bad, 0);
      req_i = 3'b000;
      step();
      pulse(3'b100);
      burst(3'b100, 8, -1, w);
      gap_rest();

      // Enable low mid-burst freezes the burst; it completes afterwards.
      do_reset();
      pulse(3'b001);
      burst(3'b001, 2, 9, w);
      gap_rest();

      // Asynchronous reset mid-burst with pend=110.
      do_reset();
      pulse(3'b001);
      step();
      req_i = 3'b110;
      step();
      req_i = 3'b000;
      step();
      chk("pre_rst", {26'd0, grant_o, pend_o}, {26'd0, 3'b001, 3'b110});
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {24'd0, buzz_o, busy_o, grant_o, pend_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (grant_o !== 3'b000 || pend_o !== 3'b000 || busy_o !== 1'b0) bad++;
      end
      chk("post_rst_quiet", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single piezo buzzer pin between three alarm requesters, such as the debounced outputs of the sensor-to-buzzer detector.
- Latches a rising-edge request from each requester as a sticky pending bit.
- Grants requesters one at a time, round-robin, each for a fixed burst followed by a silent gap.
- During a burst it drives a square-wave tone whose pitch identifies the granted requester.
- Sits between the detector outputs and the top-level output pin.

Parameters:
ON_CYC, 31, burst length in clk cycles while a grant is active (1..255)
GAP_CYC, 4, silent cycles after each burst before the next arbitration (1..255)
TONE_HALF, 2, base tone half-period in cycles; requester i uses TONE_HALF<<i (1..32)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when low, all state and outputs hold
req_i  input  3  per-requester alarm request, level; rising edge registers a request
buzz_o  output  1  buzzer drive: square wave during a burst, 0 otherwise
grant_o  output  3  one-hot index of the requester being sounded; 0 when none
pend_o  output  3  pending (requested, not yet granted) bits
busy_o  output  1  high in ON or GAP

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE; buzz_o=0; grant_o=0; pend_o=0; busy_o=0
  - rr pointer=0 (requester 0 has first priority)
  - req_i previous-value register=0
  - all counters=0
- ena=0: no register changes, including edge history. A req_i edge that spans only ena-low cycles is evaluated on the first ena-high cycle against the held previous value.
- Edge detect: pend[i] is set in the cycle after req_i[i]==1 while prev[i]==0. A level held high sets pend once only.
- States (2-bit encoding):
  - IDLE=0
  - ON=1
  - GAP=2
  - 3 is illegal and returns to IDLE with outputs cleared.
- IDLE:
  - If pend!=0, choose winner w: the first set pend bit scanning from rr, rr+1, rr+2 (mod 3).
  - Next cycle: state=ON, grant_o=onehot(w), pend[w] cleared, on-timer=ON_CYC-1, tone counter=0, buzz_o=1, rr=(w+1) mod 3.
  - Arbitration latency from pend visible to grant: 1 cycle.
- ON:
  - The tone counter counts to (TONE_HALF<<w)-1, then toggles buzz_o and wraps to 0.
  - The on-timer decrements every cycle.
  - When on-timer==0: next state GAP, grant_o=0, buzz_o=0, gap-timer=GAP_CYC-1.
  - The burst occupies exactly ON_CYC cycles with grant_o nonzero.
- GAP: gap-timer decrements; at 0 go to IDLE. There is exactly GAP_CYC silent cycles between bursts, plus 1 IDLE arbitration cycle.
- Simultaneous events:
  - A new edge on w in the same cycle its pend bit is cleared leaves pend[w]=1 (set wins), so w is re-queued.
  - Edges during ON or GAP only set pend and never preempt the current burst.
- Counter widths:
  - on/gap timer: 8 bits
  - tone counter: 8 bits (TONE_HALF<<2 ≤ 128)
  - No wrap beyond the load value.
- Asynchronous reset mid-burst: buzz_o and grant_o drop immediately and pend is lost.

Optional Feature:
- Macro: BUZZER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin. The winner is the lowest set pend index (req 0 highest); the rr register is absent and not updated.
- Undefined: round-robin as described above.

Decomposition:
- Shared package `buzzer_pkg`:
  - state typedef (IDLE/ON/GAP)
  - NUM_REQ=3
  - TIMER_W=8
  - one-hot/index helper function
- Natural sub-module `rr_pick3`: combinational pick of (pend, rr) -> winner index plus valid. It also implements the fixed-priority variant under the macro.
- The FSM, timers and tone generator stay in the top.

Test Plan:
- Reset, then req_i=3'b001 pulse:
  - pend_o=001 one cycle after the edge
  - grant_o=001 the next cycle
  - buzz_o toggles every 2 cycles for 31 cycles
  - 4 silent cycles, then busy_o=0
- req_i=3'b111 on the same edge:
  - grants in order 001, 010, 100
  - tone half-periods of 2, 4 and 8 cycles
  - each burst 31 cycles, separated by 4+1 idle cycles
- After requester 0 is granted, raise req 0 and req 1 again during the GAP: the next grant is 010 (rr=1), then 001.
- req_i[2] held high for 200 cycles: exactly one burst; pend never re-sets without a falling then rising edge.
- ena=0 for 10 cycles mid-burst: buzz_o, grant_o and the timers are frozen; the burst completes its remaining cycles after ena returns.
- rst_n asserted asynchronously mid-burst with pend=110: outputs are 0 immediately, pend_o=0, and no grant follows after release.
